// File: rtl/seq_int_control.sv
// Sequence counter, timing decode and interrupt/device flip-flops of the basic computer.
// Build option SIC_INTERRUPT_EN enables the R (interrupt cycle) and IEN flip-flops.
module seq_int_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    input  logic        start,
    input  logic        in_strobe,
    input  logic        out_done,
    output logic [7:0]  T,
    output logic [7:0]  D,
    output logic [15:0] B,
    output logic        I,
    output logic        R,
    output logic        IEN,
    output logic        FGI,
    output logic        FGO,
    output logic        S,
    output logic        sc_clr
);

    logic [2:0] sc;
    logic       r_exec;
    logic       p_exec;
    logic       int_clr;

    assign T = 8'h01 << sc;
    assign D = 8'h01 << IR[14:12];
    assign B = {4'b0000, IR[11:0]};

    // Register-reference (r) and I/O (p) instructions both finish in T3.
    assign r_exec = D[7] & ~I & T[3];
    assign p_exec = D[7] &  I & T[3];

`ifdef SIC_INTERRUPT_EN
    logic int_set;
    logic r_q;
    logic ien_q;

    // Flags and IEN are the pre-edge register values, so a flag set this cycle
    // is seen by the interrupt request one clock later.
    assign int_set = ~T[0] & ~T[1] & ~T[2] & ien_q & (FGI | FGO);
    assign int_clr = r_q & T[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= 1'b0;
            ien_q <= 1'b0;
        end else begin
            if (int_clr)
                r_q <= 1'b0;
            else if (int_set)
                r_q <= 1'b1;

            if ((p_exec & B[6]) | int_clr)
                ien_q <= 1'b0;
            else if (p_exec & B[7])
                ien_q <= 1'b1;
        end
    end

    assign R   = r_q;
    assign IEN = ien_q;
`else
    assign int_clr = 1'b0;
    assign R       = 1'b0;
    assign IEN     = 1'b0;
`endif

    assign sc_clr = int_clr | r_exec | p_exec
                  | (D[0] & T[5]) | (D[1] & T[5]) | (D[2] & T[5])
                  | (D[3] & T[4]) | (D[4] & T[4])
                  | (D[5] & T[5]) | (D[6] & T[6]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sc <= 3'd0;
        else if (sc_clr)
            sc <= 3'd0;
        else if (S)
            sc <= sc + 3'd1;
    end

    // I is not reloaded during the interrupt cycle so the interrupted state is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            I   <= 1'b0;
            S   <= 1'b1;
            FGI <= 1'b0;
            FGO <= 1'b1;
        end else begin
            if (~R & T[2])
                I <= IR[15];

            if (start)
                S <= 1'b1;
            else if (r_exec & B[0])
                S <= 1'b0;

            if (in_strobe)
                FGI <= 1'b1;
            else if (p_exec & B[11])
                FGI <= 1'b0;

            if (out_done)
                FGO <= 1'b1;
            else if (p_exec & B[10])
                FGO <= 1'b0;
        end
    end

endmodule
